// File: rtl/perf_counter_sampler.sv
// Performance-counter sweep sampler: shares the counter-bank port with CSR accesses and
// streams (index, value) samples through a FWFT FIFO. Optional macro: PERF_SAMPLE_CLEAR_EN.
module perf_counter_sampler #(
   parameter int unsigned XLEN        = 64,
   parameter logic [4:0]  FIRST_ADDR  = 5'd3,
   parameter int unsigned NR_COUNTERS = 14,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PERIOD_W    = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                debug_mode_i,
   input  logic                csr_req_i,
   input  logic [4:0]          csr_addr_i,
   input  logic                csr_we_i,
   input  logic [XLEN-1:0]     csr_wdata_i,
   output logic [XLEN-1:0]     csr_rdata_o,
   input  logic                trigger_i,
   input  logic [PERIOD_W-1:0] cfg_period_i,
   output logic [4:0]          pc_addr_o,
   output logic                pc_we_o,
   output logic [XLEN-1:0]     pc_wdata_o,
   input  logic [XLEN-1:0]     pc_rdata_i,
   output logic                smp_valid_o,
   input  logic                smp_ready_i,
   output logic [4:0]          smp_idx_o,
   output logic [XLEN-1:0]     smp_data_o,
   output logic                smp_last_o,
   output logic                busy_o,
   output logic                overrun_o
);

`ifdef PERF_SAMPLE_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam int unsigned PW       = AW + 1;
   localparam logic [4:0]  LAST_IDX = 5'(NR_COUNTERS - 1);

   typedef struct packed {
      logic [4:0]      idx;
      logic [XLEN-1:0] data;
      logic            last;
   } sample_t;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t              state_q;
   logic                pending_q;
   logic                overrun_q;
   logic [PERIOD_W-1:0] timer_q;
   logic [4:0]          idx_q;
   sample_t             fifo_q [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q;
   logic [PW-1:0]       rd_ptr_q;

   logic       tick_c;
   logic       start_req_c;
   logic       empty_c;
   logic       full_c;
   logic       pop_c;
   logic       read_c;
   logic       last_c;
   logic [4:0] smp_addr_c;
   sample_t    head_c;

   assign tick_c      = (cfg_period_i != '0) && !debug_mode_i &&
                        (timer_q >= (cfg_period_i - PERIOD_W'(1)));
   assign start_req_c = (trigger_i | tick_c) & ~debug_mode_i;

   assign empty_c = (wr_ptr_q == rd_ptr_q);
   assign full_c  = ((wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH));
   assign pop_c   = !empty_c && smp_ready_i;

   // A full FIFO still accepts a push when its head leaves in the same cycle.
   assign read_c     = (state_q == SWEEP) && !csr_req_i && (!full_c || smp_ready_i);
   assign last_c     = (idx_q == LAST_IDX);
   assign smp_addr_c = FIRST_ADDR + idx_q;

   // Shared counter-bank port: the CSR file always wins.
   always_comb begin
      csr_rdata_o = pc_rdata_i;
      pc_addr_o   = smp_addr_c;
      pc_we_o     = 1'b0;
      pc_wdata_o  = '0;
      if (csr_req_i) begin
         pc_addr_o  = csr_addr_i;
         pc_we_o    = csr_we_i;
         pc_wdata_o = csr_wdata_i;
      end else begin
         pc_we_o = CLEAR_EN & read_c;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         timer_q   <= '0;
         idx_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         if (cfg_period_i == '0) begin
            timer_q <= '0;
         end else if (!debug_mode_i) begin
            timer_q <= tick_c ? '0 : timer_q + PERIOD_W'(1);
         end

         overrun_q <= start_req_c & pending_q;
         if ((state_q == IDLE) && pending_q) begin
            pending_q <= 1'b0;
         end else if (start_req_c) begin
            pending_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (pending_q) begin
                  state_q <= SWEEP;
                  idx_q   <= '0;
               end
            end
            SWEEP: begin
               if (read_c) begin
                  idx_q <= last_c ? 5'd0 : idx_q + 5'd1;
                  if (last_c) begin
                     state_q <= IDLE;
                  end
               end
            end
         endcase

         if (read_c) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= '{idx: smp_addr_c, data: pc_rdata_i, last: last_c};
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   assign head_c      = fifo_q[rd_ptr_q[AW-1:0]];
   assign smp_valid_o = !empty_c;
   assign smp_idx_o   = head_c.idx;
   assign smp_data_o  = head_c.data;
   assign smp_last_o  = head_c.last;
   assign busy_o      = (state_q == SWEEP);
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Self-checking bench for perf_counter_sampler: port-mux vector table, directed sweep
// sequences and a randomized run checked against a sweep-stream reference model.
module tb_perf_counter_sampler;
   localparam int unsigned XLEN  = 64;
   localparam int unsigned NR    = 14;
   localparam int unsigned FIRST = 3;
   localparam int unsigned PW    = 16;
`ifdef PERF_SAMPLE_CLEAR_EN
   localparam bit CLEAR = 1'b1;
`else
   localparam bit CLEAR = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n, debug_mode, csr_req, csr_we, trigger, smp_ready;
   logic [4:0]      csr_addr;
   logic [XLEN-1:0] csr_wdata, csr_rdata;
   logic [PW-1:0]   cfg_period;
   logic [4:0]      pc_addr;
   logic            pc_we;
   logic [XLEN-1:0] pc_wdata, pc_rdata;
   logic            smp_valid, smp_last, busy, overrun;
   logic [4:0]      smp_idx;
   logic [XLEN-1:0] smp_data;
   logic [XLEN-1:0] bank [32];

   perf_counter_sampler dut (
      .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug_mode),
      .csr_req_i(csr_req), .csr_addr_i(csr_addr), .csr_we_i(csr_we),
      .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
      .trigger_i(trigger), .cfg_period_i(cfg_period),
      .pc_addr_o(pc_addr), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata), .pc_rdata_i(pc_rdata),
      .smp_valid_o(smp_valid), .smp_ready_i(smp_ready), .smp_idx_o(smp_idx),
      .smp_data_o(smp_data), .smp_last_o(smp_last), .busy_o(busy), .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   // Counter bank: combinational read, write-after-read, preloaded with 100+k while in reset.
   assign pc_rdata = bank[pc_addr];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 32; k++) bank[k] <= XLEN'(100 + k);
      end else if (pc_we) begin
         bank[pc_addr] <= pc_wdata;
      end
   end

   typedef struct packed {
      logic            rst_n, trig, req, we, ready, dbg;
      logic [4:0]      addr;
      logic [XLEN-1:0] wdata;
      logic [PW-1:0]   period;
   } drv_t;

   typedef struct packed {
      logic [4:0]      idx;
      logic [XLEN-1:0] data;
      logic            last;
   } ent_t;

   typedef struct packed {
      logic            req, we;
      logic [4:0]      addr;
      logic [XLEN-1:0] wdata;
      logic [4:0]      e_addr;
      logic            e_we;
      logic [XLEN-1:0] e_wdata, e_rdata;
   } vec_t;

   drv_t d;
   ent_t got [$];
   int   checks, failures;
   int   cyc, busy_cnt, ovr_cnt, dbl_ovr, clr_cnt, first_busy, first_valid, first_ovr;
   bit   prev_ovr, mux_chk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive at the falling edge, observe 1 ns later.
   task automatic step();
      @(negedge clk);
      rst_n = d.rst_n;  trigger = d.trig;  csr_req = d.req;  csr_addr = d.addr;
      csr_we = d.we;    csr_wdata = d.wdata; smp_ready = d.ready; debug_mode = d.dbg;
      cfg_period = d.period;
      #1;
      if (rst_n && smp_valid && smp_ready) got.push_back(ent_t'({smp_idx, smp_data, smp_last}));
      if (busy) begin
         busy_cnt++;
         if (first_busy < 0) first_busy = cyc;
      end
      if (smp_valid && first_valid < 0) first_valid = cyc;
      if (overrun) begin
         ovr_cnt++;
         if (first_ovr < 0) first_ovr = cyc;
         if (prev_ovr) dbl_ovr++;
      end
      prev_ovr = overrun;
      if (busy && !csr_req && pc_we && pc_wdata == '0) clr_cnt++;
      if (mux_chk && csr_req) begin
         check("rand_csr_addr", 128'(pc_addr), 128'(csr_addr));
         check("rand_csr_we", 128'(pc_we), 128'(csr_we));
      end
      cyc++;
   endtask

   task automatic clear_stats();
      got.delete();
      cyc = 0; busy_cnt = 0; ovr_cnt = 0; dbl_ovr = 0; clr_cnt = 0;
      first_busy = -1; first_valid = -1; first_ovr = -1; prev_ovr = 1'b0;
   endtask

   task automatic do_reset(input logic [PW-1:0] period);
      d = '0;
      d.ready  = 1'b1;
      d.period = period;
      mux_chk  = 1'b0;
      repeat (2) step();
      d.rst_n = 1'b1;
      clear_stats();
   endtask

   // Reference: accepted samples form back-to-back complete sweeps of FIRST..FIRST+NR-1.
   task automatic check_stream(input string name, input int exp_entries);
      check({name, "_count"}, 128'(got.size()), 128'(exp_entries));
      for (int i = 0; i < got.size() && i < exp_entries; i++) begin
         ent_t e;
         int   k;
         k      = i % int'(NR);
         e.idx  = 5'(int'(FIRST) + k);
         e.data = (CLEAR && (i / int'(NR)) > 0) ? '0 : XLEN'(100 + int'(FIRST) + k);
         e.last = (k == int'(NR) - 1);
         check(name, 128'(got[i]), 128'(e));
      end
   endtask

   vec_t vecs [8];
   int   trig_acc;
   bit   found;

   initial begin
      checks = 0; failures = 0; d = '0; mux_chk = 1'b0;
      clear_stats();

      do_reset('0);
      step();
      check("reset_valid", 128'(smp_valid), 128'(0));
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_overrun", 128'(overrun), 128'(0));

      vecs[0] = '{req:0, we:1, addr:7,  wdata:64'h55,  e_addr:3,  e_we:0, e_wdata:0,      e_rdata:64'd103};
      vecs[1] = '{req:1, we:0, addr:7,  wdata:64'h55,  e_addr:7,  e_we:0, e_wdata:64'h55, e_rdata:64'd107};
      vecs[2] = '{req:1, we:1, addr:20, wdata:64'habc, e_addr:20, e_we:1, e_wdata:64'habc, e_rdata:64'd120};
      vecs[3] = '{req:1, we:0, addr:20, wdata:64'h0,   e_addr:20, e_we:0, e_wdata:0,      e_rdata:64'habc};
      vecs[4] = '{req:1, we:1, addr:1,  wdata:64'h1234_5678_9abc_def0, e_addr:1, e_we:1,
                  e_wdata:64'h1234_5678_9abc_def0, e_rdata:64'd101};
      vecs[5] = '{req:1, we:0, addr:1,  wdata:64'h0,   e_addr:1,  e_we:0, e_wdata:0,
                  e_rdata:64'h1234_5678_9abc_def0};
      vecs[6] = '{req:1, we:0, addr:31, wdata:64'h7,   e_addr:31, e_we:0, e_wdata:64'h7,  e_rdata:64'd131};
      vecs[7] = '{req:0, we:0, addr:31, wdata:64'h7,   e_addr:3,  e_we:0, e_wdata:0,      e_rdata:64'd103};
      for (int v = 0; v < 8; v++) begin
         d.req = vecs[v].req; d.we = vecs[v].we; d.addr = vecs[v].addr; d.wdata = vecs[v].wdata;
         step();
         check("mux_addr", 128'(pc_addr), 128'(vecs[v].e_addr));
         check("mux_we", 128'(pc_we), 128'(vecs[v].e_we));
         check("mux_wdata", 128'(pc_wdata), 128'(vecs[v].e_wdata));
         check("mux_rdata", 128'(csr_rdata), 128'(vecs[v].e_rdata));
      end

      // Single sweep with an always-ready consumer.
      do_reset('0);
      d.trig = 1'b1; step(); d.trig = 1'b0;
      repeat (30) step();
      check("single_first_busy", 128'(first_busy), 128'(2));
      check("single_first_valid", 128'(first_valid), 128'(3));
      check("single_busy_cycles", 128'(busy_cnt), 128'(NR));
      check("single_busy_end", 128'(busy), 128'(0));
      check("single_clear_writes", 128'(clr_cnt), 128'(CLEAR ? NR : 0));
      check_stream("single", int'(NR));
      d.req = 1'b1; d.addr = 5'(FIRST); step(); d.req = 1'b0;
      check("readback_after_sweep", 128'(csr_rdata), 128'(CLEAR ? 0 : 100 + FIRST));

      // CSR steals the port for three cycles mid-sweep.
      do_reset('0);
      d.trig = 1'b1; step(); d.trig = 1'b0;
      repeat (7) step();
      d.req = 1'b1; d.addr = 5'd25;
      repeat (3) begin
         step();
         check("csr_prio_addr", 128'(pc_addr), 128'(25));
      end
      d.req = 1'b0;
      repeat (30) step();
      check("csr_prio_busy_cycles", 128'(busy_cnt), 128'(NR + 3));
      check_stream("csr_prio", int'(NR));

      // Backpressure: FIFO fills, sweep stalls, then drains in order.
      do_reset('0);
      d.ready = 1'b0;
      d.trig = 1'b1; step(); d.trig = 1'b0;
      repeat (30) step();
      check("bp_busy_held", 128'(busy), 128'(1));
      check("bp_valid", 128'(smp_valid), 128'(1));
      check("bp_head_idx", 128'(smp_idx), 128'(FIRST));
      busy_cnt = 0;
      d.ready = 1'b1;
      repeat (30) step();
      check("bp_remaining_reads", 128'(busy_cnt), 128'(NR - 4));
      check_stream("bp", int'(NR));

      // Periodic ticks every 8 cycles with a stalled consumer.
      do_reset(16'd8);
      d.ready = 1'b0;
      repeat (36) step();
      check("period_first_busy", 128'(first_busy), 128'(9));
      check("period_first_overrun", 128'(first_ovr), 128'(24));
      check("period_overrun_count", 128'(ovr_cnt), 128'(2));
      check("period_overrun_pulse", 128'(dbl_ovr), 128'(0));

      // Reset while the sweep is at counter 5.
      do_reset('0);
      d.trig = 1'b1; step(); d.trig = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         step();
         if (smp_valid && smp_idx == 5'd5) found = 1'b1;
      end
      check("rst_mid_idx5_seen", 128'(found), 128'(1));
      d.rst_n = 1'b0; step(); d.rst_n = 1'b1; step();
      check("rst_mid_valid", 128'(smp_valid), 128'(0));
      check("rst_mid_busy", 128'(busy), 128'(0));
      clear_stats();
      d.trig = 1'b1; step(); d.trig = 1'b0;
      repeat (30) step();
      check_stream("rst_restart", int'(NR));

      // Randomized traffic: CSR reads, backpressure, debug mode, triggers.
      do_reset('0);
      mux_chk = 1'b1;
      trig_acc = 0;
      for (int n = 0; n < 800; n++) begin
         d.trig  = ($urandom_range(0, 23) == 0);
         d.dbg   = ($urandom_range(0, 9) == 0);
         d.req   = ($urandom_range(0, 3) == 0);
         d.addr  = 5'($urandom);
         d.we    = 1'b0;
         d.ready = 1'($urandom);
         step();
         if (d.trig && !d.dbg) trig_acc++;
      end
      d.trig = 1'b0; d.dbg = 1'b0; d.req = 1'b0; d.ready = 1'b1;
      repeat (200) step();
      mux_chk = 1'b0;
      check("rand_idle_busy", 128'(busy), 128'(0));
      check("rand_idle_valid", 128'(smp_valid), 128'(0));
      check_stream("rand", int'(NR) * (trig_acc - ovr_cnt));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/perf_counter_sampler.md
# perf_counter_sampler

Sweep controller for the performance-counter bank. It shares the counter file's single SRAM-like port between the CSR file and an internal sampler. The sampler reads every counter in order, either on a one-shot trigger or on a programmable period, and streams (index, value) pairs through a small FIFO to a trace/debug consumer. It sits between the CSR file and the perf-counter bank in the core's CSR subsystem.

## Interface
Parameters:
- XLEN, 64: counter width.
- FIRST_ADDR, 5'd3: port address of the first counter.
- NR_COUNTERS, 14: counters per sweep, range 1..29. FIRST_ADDR+NR_COUNTERS-1 must be ≤ 31.
- FIFO_DEPTH, 4: sample FIFO entries, power of two, ≥ 2.
- PERIOD_W, 16: width of the sampling-period register.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, synchronous, active-low.
- debug_mode_i  in  1  core is in debug mode.
- csr_req_i  in  1  CSR access this cycle.
- csr_addr_i  in  5  CSR counter address.
- csr_we_i  in  1  CSR write.
- csr_wdata_i  in  XLEN  CSR write data.
- csr_rdata_o  out  XLEN  CSR read data; combinational copy of pc_rdata_i.
- trigger_i  in  1  one-shot sweep request, level sampled each cycle.
- cfg_period_i  in  PERIOD_W  sampling period in cycles; 0 disables periodic sweeps.
- pc_addr_o  out  5  counter-bank address.
- pc_we_o  out  1  counter-bank write enable.
- pc_wdata_o  out  XLEN  counter-bank write data.
- pc_rdata_i  in  XLEN  counter-bank read data, combinational from pc_addr_o.
- smp_valid_o  out  1  FIFO head valid.
- smp_ready_i  in  1  consumer accepts the head.
- smp_idx_o  out  5  counter address of the head entry.
- smp_data_o  out  XLEN  counter value of the head entry.
- smp_last_o  out  1  head entry is the final counter of a sweep.
- busy_o  out  1  sweep in progress (state SWEEP).
- overrun_o  out  1  one-cycle pulse: a start request was dropped.

## Operation
- **Port mux:**
  - csr_req_i=1: the port carries csr_addr_i, csr_we_i and csr_wdata_i. The CSR always wins.
  - Otherwise the sampler drives the port. pc_we_o=0 unless PERF_SAMPLE_CLEAR_EN applies.
- **Period timer:**
  - timer_q increments each cycle while cfg_period_i≠0 and debug_mode_i=0.
  - tick fires when timer_q ≥ cfg_period_i-1. On tick, timer_q returns to 0.
  - cfg_period_i=0 holds timer_q at 0.
- **Start request:** trigger_i | tick.
  - pending_q set: request dropped, overrun_o=1 next cycle.
  - pending_q clear: pending_q is set.
  - Requests during debug_mode_i are ignored, with no overrun.
- **FSM:**
  - IDLE: if pending_q, go to SWEEP, clear pending_q, set idx_q=0.
  - SWEEP: a read cycle occurs when csr_req_i=0 and the FIFO is not full. In that cycle:
    - pc_addr_o=FIRST_ADDR+idx_q;
    - push {addr, pc_rdata_i, last=(idx_q==NR_COUNTERS-1)};
    - increment idx_q.
  - SWEEP: the read cycle with last=1 returns the FSM to IDLE.
  - SWEEP, cycle not a read cycle: stall, idx_q holds.
  - A pending_q set during SWEEP starts the next sweep from IDLE.
- **FIFO:** standard valid/ready, first-word fall-through.
  - Push and pop in the same cycle are allowed when full; occupancy is unchanged.
  - A full FIFO stalls the sweep. No sample is ever lost or duplicated.

## Timing
- Reset values: state IDLE, pending_q=0, timer_q=0, idx_q=0, FIFO empty, smp_valid_o=0, busy_o=0, overrun_o=0.
- csr_rdata_o, pc_addr_o, pc_we_o and pc_wdata_o are combinational, with no added latency.
- Latency: trigger at cycle T sets pending at T+1. SWEEP is entered at T+2, first read at T+2, and smp_valid_o at T+3.
- Minimum sweep is NR_COUNTERS cycles. Each CSR cycle or full-FIFO cycle adds one.
- Reset mid-sweep: the sweep is aborted, FIFO contents are discarded, and no partial last entry is kept.

## Configuration
- PERF_SAMPLE_CLEAR_EN defined: each sampler read cycle also drives pc_we_o=1 and pc_wdata_o=0.
  - Read-and-clear relies on the bank's write-after-read behaviour.
  - An increment of that counter in the same cycle is lost.
- PERF_SAMPLE_CLEAR_EN undefined: the sampler never writes, and pc_we_o follows csr_we_i only when csr_req_i=1.

## Test plan
- **Single sweep:** reset, bank preloaded with counter k = 100+k, smp_ready_i=1, pulse trigger_i. Expect 14 entries, idx 3..16, data 103..116, smp_last_o only on idx 16, then busy_o=0.
- **CSR priority:** hold csr_req_i=1 for 3 cycles mid-sweep. Expect the CSR address on pc_addr_o in those cycles, the sweep length extended by exactly 3, and no skipped or duplicated index.
- **Backpressure:** smp_ready_i=0. Expect exactly FIFO_DEPTH=4 entries buffered and busy_o held. Then release: the remaining 10 entries follow in order.
- **Periodic and overrun:** cfg_period_i=8, smp_ready_i=0. Expect a tick every 8 cycles. The second tick during the sweep sets pending; the third tick pulses overrun_o for one cycle.
- **Clear build:** with PERF_SAMPLE_CLEAR_EN, run one sweep. Expect pc_we_o=1 with data 0 on each read cycle, a CSR readback of 0 afterwards, and sampled values unchanged from preload.
- **Reset mid-sweep:** assert rst_ni=0 during idx 5. Next cycle expect smp_valid_o=0 and busy_o=0. A fresh trigger restarts at idx 3.
